ex_result_sel: RTL and testbench

//  Parametrised EX-stage result selector with a registered, elastic output for the 5-stage CPU.
//  - Picks one of NUM_SRC result buses (ALU, HI, LO, shifter, ...) by sel.
//  - Carries the selected word and its destination register index into EX/MEM.
//  - Uses a valid/ready handshake with a 2-entry skid buffer, so a MEM-side stall never drops a result.
//  - in_ready is registered, so the stall does not ripple combinationally into EX.

---
 rtl/ex_result_sel.sv | 110 +++++++++++
 tb/tb_ex_result_sel.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_result_sel.sv
// rtl/ex_result_sel.sv - EX-stage result selector with registered valid/ready output and 2-entry skid buffer
// Optional feature macro: SEL_CHECK_EN (adds out_sel_err flag per result)
module ex_result_sel #(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2,
   parameter int REG_W   = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [SEL_W-1:0]          sel,
   input  logic [REG_W-1:0]          in_rd,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
`ifdef SEL_CHECK_EN
   output logic                      out_sel_err,
`endif
   output logic [REG_W-1:0]          out_rd
);

   logic [DATA_W-1:0] sel_data;
   logic              accept;
   logic              m_valid, s_valid;
   logic [DATA_W-1:0] m_data, s_data;
   logic [REG_W-1:0]  m_rd, s_rd;
`ifdef SEL_CHECK_EN
   logic              sel_err;
   logic              m_err, s_err;
`endif

   // Out-of-range sel matches no source and falls through to zero.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) sel_data = src_data[i*DATA_W +: DATA_W];
      end
   end

`ifdef SEL_CHECK_EN
   assign sel_err = ({1'b0, sel} >= (SEL_W+1)'(NUM_SRC));
`endif

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid  <= 1'b0;
         s_valid  <= 1'b0;
         m_data   <= '0;
         s_data   <= '0;
         m_rd     <= '0;
         s_rd     <= '0;
         in_ready <= 1'b1;
`ifdef SEL_CHECK_EN
         m_err    <= 1'b0;
         s_err    <= 1'b0;
`endif
      end else if (flush) begin
         m_valid  <= 1'b0;
         s_valid  <= 1'b0;
         in_ready <= 1'b1;
`ifdef SEL_CHECK_EN
         m_err    <= 1'b0;
         s_err    <= 1'b0;
`endif
      end else if (!m_valid || out_ready) begin
         if (s_valid) begin
            // in_ready was low, so no input can be accepted this cycle.
            m_valid  <= 1'b1;
            m_data   <= s_data;
            m_rd     <= s_rd;
            s_valid  <= 1'b0;
            in_ready <= 1'b1;
`ifdef SEL_CHECK_EN
            m_err    <= s_err;
`endif
         end else begin
            m_valid <= accept;
            if (accept) begin
               m_data <= sel_data;
               m_rd   <= in_rd;
`ifdef SEL_CHECK_EN
               m_err  <= sel_err;
`endif
            end
         end
      end else if (accept) begin
         s_valid  <= 1'b1;
         s_data   <= sel_data;
         s_rd     <= in_rd;
         in_ready <= 1'b0;
`ifdef SEL_CHECK_EN
         s_err    <= sel_err;
`endif
      end
   end

   assign out_valid = m_valid;
   assign out_data  = m_data;
   assign out_rd    = m_rd;
`ifdef SEL_CHECK_EN
   assign out_sel_err = m_err;
`endif

endmodule

// File: tb/tb_ex_result_sel.sv
// tb/tb_ex_result_sel.sv - directed and scoreboard bench for ex_result_sel
module tb_ex_result_sel;

   logic         clk = 1'b0;
   logic         rst_n, flush, in_valid, out_ready;
   logic [127:0] src_data;
   logic [95:0]  src3;
   logic [1:0]   sel;
   logic [4:0]   in_rd;
   logic         in_ready, out_valid, in_ready3, out_valid3;
   logic [31:0]  out_data, out_data3;
   logic [4:0]   out_rd, out_rd3;
`ifdef SEL_CHECK_EN
   logic         out_sel_err, out_sel_err3;
`endif

   int checks = 0;
   int errors = 0;
   logic [36:0] q[$];
   logic [36:0] exp_e;

   always #5 clk = ~clk;
   assign src3 = src_data[95:0];

   ex_result_sel dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .src_data(src_data), .sel(sel), .in_rd(in_rd), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data),
`ifdef SEL_CHECK_EN
      .out_sel_err(out_sel_err),
`endif
      .out_rd(out_rd)
   );

   ex_result_sel #(.NUM_SRC(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
      .src_data(src3), .sel(sel), .in_rd(in_rd), .out_valid(out_valid3),
      .out_ready(out_ready), .out_data(out_data3),
`ifdef SEL_CHECK_EN
      .out_sel_err(out_sel_err3),
`endif
      .out_rd(out_rd3)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      sel = 2'd0; in_rd = 5'd0;
      src_data = {32'h44, 32'h33, 32'h22, 32'h11};

      // Reset
      tick(); tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_ready", in_ready, 1'b1);
      check("rst_data", out_data, 32'h0);
      rst_n = 1'b1;
      tick();
      check("rel_valid", out_valid, 1'b0);
      check("rel_ready", in_ready, 1'b1);
      check("rel_data", out_data, 32'h0);

      // Back-to-back stream
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; sel = 2'(i); in_rd = 5'(i + 1);
         tick();
         check("str_valid", out_valid, 1'b1);
         check("str_data", out_data, 64'((i + 1) * 32'h11));
         check("str_rd", out_rd, 64'(i + 1));
      end
      in_valid = 1'b0;
      tick();
      check("str_end", out_valid, 1'b0);

      // Stall with skid
      in_valid = 1'b1; sel = 2'd0; in_rd = 5'd1;
      tick();
      check("stl_a", out_data, 32'h11);
      check("stl_rdy0", in_ready, 1'b1);
      out_ready = 1'b0; sel = 2'd1; in_rd = 5'd2;
      tick();
      check("stl_hold", out_data, 32'h11);
      check("stl_rdy1", in_ready, 1'b0);
      sel = 2'd2; in_rd = 5'd3;
      tick();
      check("stl_hold2", out_data, 32'h11);
      check("stl_hold_rd", out_rd, 5'd1);
      check("stl_rdy2", in_ready, 1'b0);
      out_ready = 1'b1;
      tick();
      check("stl_b", out_data, 32'h22);
      check("stl_b_rd", out_rd, 5'd2);
      check("stl_rdy3", in_ready, 1'b1);
      tick();
      check("stl_c", out_data, 32'h33);
      check("stl_c_rd", out_rd, 5'd3);
      in_valid = 1'b0;
      tick();
      check("stl_end", out_valid, 1'b0);

      // Flush with both entries full
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; in_rd = 5'd5;
      tick();
      sel = 2'd1; in_rd = 5'd6;
      tick();
      check("fl_full_rdy", in_ready, 1'b0);
      check("fl_full_rd", out_rd, 5'd5);
      flush = 1'b1; sel = 2'd3; in_rd = 5'd4;
      tick();
      check("fl_valid", out_valid, 1'b0);
      check("fl_ready", in_ready, 1'b1);
      flush = 1'b0; out_ready = 1'b1; sel = 2'd2; in_rd = 5'd7;
      tick();
      check("fl_new_valid", out_valid, 1'b1);
      check("fl_new_rd", out_rd, 5'd7);
      check("fl_new_data", out_data, 32'h33);
      in_valid = 1'b0;
      tick();
      check("fl_new_end", out_valid, 1'b0);
      in_valid = 1'b1; in_rd = 5'd8; flush = 1'b1;
      tick();
      check("fl_drop0", out_valid, 1'b0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      check("fl_drop1", out_valid, 1'b0);

      // Out-of-range select on the 3-source instance
      in_valid = 1'b1; sel = 2'd3; in_rd = 5'd9;
      tick();
      check("oor_valid", out_valid3, 1'b1);
      check("oor_data", out_data3, 32'h0);
      check("oor_rd", out_rd3, 5'd9);
      check("oor_main", out_data, 32'h44);
`ifdef SEL_CHECK_EN
      check("oor_err", out_sel_err3, 1'b1);
      check("oor_main_err", out_sel_err, 1'b0);
`endif
      sel = 2'd2; in_rd = 5'd10;
      tick();
      check("inr_data", out_data3, 32'h33);
`ifdef SEL_CHECK_EN
      check("inr_err", out_sel_err3, 1'b0);
`endif
      in_valid = 1'b0;
      tick();
      check("oor_end", out_valid, 1'b0);

      // Random traffic against an in-order scoreboard
      for (int c = 0; c < 4000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         sel       = 2'($urandom);
         in_rd     = 5'($urandom);
         src_data  = {$urandom, $urandom, $urandom, $urandom};
         check("rnd_valid", out_valid, q.size() != 0);
         check("rnd_ready", in_ready, q.size() < 2);
         if (out_valid && out_ready && q.size() > 0) begin
            exp_e = q.pop_front();
            check("rnd_data", out_data, exp_e[31:0]);
            check("rnd_rd", out_rd, exp_e[36:32]);
         end
         if (in_valid && in_ready) q.push_back({in_rd, src_data[sel*32 +: 32]});
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
